// File: rtl/ysyx_2022040010_alu_ctrl_if.sv
// Issue/ALU/writeback bundle for the ALU controller; ctrl is the controller side.
// The upstream/ALU/writeback side uses the env modport.
interface ysyx_2022040010_alu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic        in_is_w;
  logic        in_is_lui;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_rd;
  logic [11:0] alu_op;
  logic [63:0] alu_src1;
  logic [63:0] alu_src2;
  logic        alu_32;
  logic [63:0] alu_result;
  logic        alu_over;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  modport ctrl (
    input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_is_w, in_is_lui,
           in_src1, in_src2, in_rd, alu_result, alu_over, out_ready,
    output in_ready, alu_op, alu_src1, alu_src2, alu_32, out_valid, out_result, out_rd
  );

  modport env (
    output in_valid, in_funct3, in_funct7_5, in_is_imm, in_is_w, in_is_lui,
           in_src1, in_src2, in_rd, alu_result, alu_over, out_ready,
    input  in_ready, alu_op, alu_src1, alu_src2, alu_32, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/ysyx_2022040010_alu_ctrl.sv
// ALU controller: IDLE->EXEC->RESP, result held until out_ready; accepts only in IDLE.
// ALU_CTRL_SEXT32_EN: sign-extend *W results from bit 31 (otherwise pass-through).
module ysyx_2022040010_alu_ctrl (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  ysyx_2022040010_alu_ctrl_if.ctrl bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h020;
  localparam logic [11:0] OP_SLL  = 12'h010;
  localparam logic [11:0] OP_SRL  = 12'h008;
  localparam logic [11:0] OP_SRA  = 12'h004;
  localparam logic [11:0] OP_NOP  = 12'h002;

  state_e      state_q, state_d;
  logic [11:0] alu_op_q, alu_op_d;
  logic [63:0] alu_src1_q, alu_src1_d;
  logic [63:0] alu_src2_q, alu_src2_d;
  logic [63:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        alu_32_q, alu_32_d;
  logic        is_w_q, is_w_d;

  logic [11:0] op_enc;
  logic        is_shift;
  logic [63:0] src2_enc;
  logic [63:0] result_fmt;

  always_comb begin
    op_enc   = '0;
    is_shift = 1'b0;
    if (bus.in_is_lui) begin
      op_enc = OP_NOP;
    end else begin
      case (bus.in_funct3)
        3'b000: op_enc = (bus.in_funct7_5 && !bus.in_is_imm) ? OP_SUB : OP_ADD;
        3'b001: op_enc = OP_SLL;
        3'b010: op_enc = OP_SLT;
        3'b011: op_enc = OP_SLTU;
        3'b100: op_enc = OP_XOR;
        3'b101: op_enc = bus.in_funct7_5 ? OP_SRA : OP_SRL;
        3'b110: op_enc = OP_OR;
        default: op_enc = OP_AND;
      endcase
      is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
    end
    src2_enc = bus.in_src2;
    if (is_shift) begin
      src2_enc = bus.in_is_w ? {59'd0, bus.in_src2[4:0]} : {58'd0, bus.in_src2[5:0]};
    end
  end

`ifdef ALU_CTRL_SEXT32_EN
  assign result_fmt = is_w_q ? {{32{bus.alu_result[31]}}, bus.alu_result[31:0]}
                             : bus.alu_result;
`else
  assign result_fmt = bus.alu_result;
`endif

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    alu_32_d     = alu_32_q;
    is_w_d       = is_w_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    // flush beats any handshake in the same cycle
    if (flush) begin
      state_d  = IDLE;
      alu_op_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_d    = EXEC;
          alu_op_d   = op_enc;
          alu_src1_d = bus.in_src1;
          alu_src2_d = src2_enc;
          alu_32_d   = bus.in_is_w && !bus.in_is_lui && (bus.in_funct3 == 3'b000);
          is_w_d     = bus.in_is_w;
          out_rd_d   = bus.in_rd;
        end
        EXEC: if ((alu_op_q != '0) && bus.alu_over) begin
          state_d      = RESP;
          alu_op_d     = '0;
          out_result_d = result_fmt;
        end
        RESP: if (bus.out_ready) state_d = IDLE;
        default: begin
          state_d  = IDLE;
          alu_op_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      alu_32_q     <= 1'b0;
      is_w_q       <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      alu_32_q     <= alu_32_d;
      is_w_q       <= is_w_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == RESP);
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_src1   = alu_src1_q;
  assign bus.alu_src2   = alu_src2_q;
  assign bus.alu_32     = alu_32_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
endmodule

// File: tb/tb_ysyx_2022040010_alu_ctrl.sv
// Directed bench for the ALU controller; a one-cycle registered ALU model answers alu_op.
module tb_ysyx_2022040010_alu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  ysyx_2022040010_alu_ctrl_if bus ();

  ysyx_2022040010_alu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic        alu_over_q;
  logic [63:0] alu_res_q;

  // 32-bit add/sub results are deliberately returned raw so the controller's W handling shows.
  function automatic logic [63:0] alu_model(input logic [11:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      12'h800: return a + b;
      12'h400: return a - b;
      12'h200: return {63'd0, $signed(a) < $signed(b)};
      12'h100: return {63'd0, a < b};
      12'h080: return a & b;
      12'h040: return a | b;
      12'h020: return a ^ b;
      12'h010: return a << b[5:0];
      12'h008: return a >> b[5:0];
      12'h004: return $unsigned($signed(a) >>> b[5:0]);
      12'h002: return b;
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_over_q <= 1'b0;
      alu_res_q  <= '0;
    end else begin
      alu_over_q <= (bus.alu_op != 12'd0) && !alu_over_q;
      alu_res_q  <= alu_model(bus.alu_op, bus.alu_src1, bus.alu_src2);
    end
  end
  assign bus.alu_over   = alu_over_q;
  assign bus.alu_result = alu_res_q;

  logic [11:0] op_seen;
  logic [63:0] src2_seen;
  logic        a32_seen;
  int          lat;

  task automatic issue(input logic [2:0] f3, input logic f7, input logic imm, input logic w,
                       input logic lui, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_funct3 = f3; bus.in_funct7_5 = f7; bus.in_is_imm = imm;
    bus.in_is_w = w; bus.in_is_lui = lui; bus.in_src1 = s1; bus.in_src2 = s2; bus.in_rd = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    op_seen = bus.alu_op; src2_seen = bus.alu_src2; a32_seen = bus.alu_32;
  endtask

  task automatic wait_resp();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = k; break; end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.alu_op !== 12'd0) begin bad++; $display("FAIL rst_alu_op got=%h want=0", bus.alu_op); end
    total++;
    if (bus.out_result !== 64'd0) begin bad++; $display("FAIL rst_out_result got=%h want=0", bus.out_result); end
    total++;
    if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL rst_out_rd got=%h want=0", bus.out_rd); end
    total++;
    if (bus.alu_src1 !== 64'd0 || bus.alu_src2 !== 64'd0 || bus.alu_32 !== 1'b0) begin
      bad++; $display("FAIL rst_alu_srcs got=%h/%h/%b want=0/0/0", bus.alu_src1, bus.alu_src2, bus.alu_32);
    end
    total++;
  endtask

  task automatic test_addw();
    logic [63:0] exp;
`ifdef ALU_CTRL_SEXT32_EN
    exp = 64'hFFFF_FFFF_8000_0000;
`else
    exp = 64'h0000_0000_8000_0000;
`endif
    issue(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF, 64'd1, 5'd3);
    if (op_seen !== 12'h800) begin bad++; $display("FAIL addw_op got=%h want=800", op_seen); end
    total++;
    if (a32_seen !== 1'b1) begin bad++; $display("FAIL addw_alu32 got=%b want=1", a32_seen); end
    total++;
    wait_resp();
    if (lat != 2) begin bad++; $display("FAIL addw_latency got=%0d want=2", lat); end
    total++;
    if (bus.out_result !== exp) begin bad++; $display("FAIL addw_result got=%h want=%h", bus.out_result, exp); end
    total++;
    if (bus.out_rd !== 5'd3 || bus.alu_op !== 12'd0) begin
      bad++; $display("FAIL addw_rd_op got=%h/%h want=3/000", bus.out_rd, bus.alu_op);
    end
    total++;
    drain();
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL addw_idle got=%b/%b want=1/0", bus.in_ready, bus.out_valid);
    end
    total++;
  endtask

  task automatic test_sub_addi();
    issue(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 5'd4);
    if (op_seen !== 12'h400 || a32_seen !== 1'b0) begin
      bad++; $display("FAIL sub_op got=%h/%b want=400/0", op_seen, a32_seen);
    end
    total++;
    wait_resp();
    if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      bad++; $display("FAIL sub_result got=%h want=fffffffffffffffe", bus.out_result);
    end
    total++;
    drain();
    issue(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'd5, 64'd7, 5'd5);
    if (op_seen !== 12'h800) begin bad++; $display("FAIL addi_op got=%h want=800", op_seen); end
    total++;
    wait_resp();
    if (bus.out_result !== 64'd12) begin bad++; $display("FAIL addi_result got=%h want=c", bus.out_result); end
    total++;
    drain();
  endtask

  task automatic test_shift_mask();
    issue(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 64'd1, 64'h25, 5'd6);
    if (src2_seen !== 64'h5 || op_seen !== 12'h010 || a32_seen !== 1'b0) begin
      bad++; $display("FAIL sllw_src2 got=%h/%h/%b want=5/010/0", src2_seen, op_seen, a32_seen);
    end
    total++;
    wait_resp();
    if (bus.out_result !== 64'd32) begin bad++; $display("FAIL sllw_result got=%h want=20", bus.out_result); end
    total++;
    drain();
    issue(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'h7F, 5'd7);
    if (src2_seen !== 64'h3F) begin bad++; $display("FAIL sll_src2 got=%h want=3f", src2_seen); end
    total++;
    wait_resp();
    if (bus.out_result !== 64'h8000_0000_0000_0000) begin
      bad++; $display("FAIL sll_result got=%h want=8000000000000000", bus.out_result);
    end
    total++;
    drain();
  endtask

  task automatic test_ops();
    logic [2:0]  f3  [8] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111, 3'b000};
    logic        f7  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        lui [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [11:0] eop [8] = '{12'h200, 12'h100, 12'h020, 12'h008, 12'h004, 12'h040, 12'h080, 12'h002};
    logic [63:0] eres[8] = '{64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF3, 64'h1FFF_FFFF_FFFF_FFFE,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF3, 64'd0, 64'd3};
    for (int i = 0; i < 8; i++) begin
      issue(f3[i], f7[i], 1'b0, 1'b0, lui[i], 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 5'(i + 8));
      if (op_seen !== eop[i]) begin bad++; $display("FAIL op_enc[%0d] got=%h want=%h", i, op_seen, eop[i]); end
      total++;
      wait_resp();
      if (bus.out_result !== eres[i] || bus.out_rd !== 5'(i + 8)) begin
        bad++; $display("FAIL op_result[%0d] got=%h rd=%0d want=%h rd=%0d", i, bus.out_result,
                        bus.out_rd, eres[i], i + 8);
      end
      total++;
      drain();
    end
  endtask

  task automatic test_backpressure();
    issue(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 64'hF0, 64'h0F, 5'd21);
    wait_resp();
    bus.in_valid = 1'b1; bus.in_funct3 = 3'b000; bus.in_funct7_5 = 1'b0; bus.in_is_imm = 1'b1;
    bus.in_is_w = 1'b0; bus.in_is_lui = 1'b0; bus.in_src1 = 64'd1; bus.in_src2 = 64'd2; bus.in_rd = 5'd22;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_result !== 64'hFF || bus.out_rd !== 5'd21 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold[%0d] got=%b/%h/%0d/%b want=1/ff/21/0", c, bus.out_valid,
                        bus.out_result, bus.out_rd, bus.in_ready);
      end
      total++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_op !== 12'd0) begin
      bad++; $display("FAIL handshake_no_accept got=%b/%b/%h want=1/0/000", bus.in_ready,
                      bus.out_valid, bus.alu_op);
    end
    total++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (bus.in_ready !== 1'b0 || bus.alu_op !== 12'h800) begin
      bad++; $display("FAIL back_to_back_accept got=%b/%h want=0/800", bus.in_ready, bus.alu_op);
    end
    total++;
    wait_resp();
    if (bus.out_result !== 64'd3 || bus.out_rd !== 5'd22) begin
      bad++; $display("FAIL back_to_back_result got=%h/%0d want=3/22", bus.out_result, bus.out_rd);
    end
    total++;
    drain();
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_funct3 = 3'b000; bus.in_is_lui = 1'b0; bus.in_is_w = 1'b0;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    if (bus.in_ready !== 1'b1 || bus.alu_op !== 12'd0) begin
      bad++; $display("FAIL flush_idle got=%b/%h want=1/000", bus.in_ready, bus.alu_op);
    end
    total++;
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9, 5'd30);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (bus.in_ready !== 1'b1 || bus.alu_op !== 12'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_exec got=%b/%h/%b want=1/000/0", bus.in_ready, bus.alu_op, bus.out_valid);
    end
    total++;
    wait_resp();
    if (lat != 0) begin bad++; $display("FAIL flush_no_valid got=%0d want=0", lat); end
    total++;
  endtask

  task automatic test_reset_resp();
    issue(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd40, 64'd2, 5'd17);
    wait_resp();
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", bus.out_valid); end
    total++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 64'd0 || bus.out_rd !== 5'd0 ||
        bus.alu_op !== 12'd0 || bus.alu_src1 !== 64'd0 || bus.alu_src2 !== 64'd0 || bus.alu_32 !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b/%h/%0d/%h want=0/0/0/000", bus.out_valid,
                      bus.out_result, bus.out_rd, bus.alu_op);
    end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset got=%b/%b want=1/0", bus.in_ready, bus.out_valid);
    end
    total++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_funct7_5 = 1'b0; bus.in_is_imm = 1'b0;
    bus.in_is_w = 1'b0; bus.in_is_lui = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0; bus.in_rd = '0;
    bus.out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_addw();
    test_sub_addi();
    test_shift_mask();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
